fpu_mul_responder: RTL and testbench

Multi-cycle integer multiplier that sits on the ALU side of the FPU multiply interface. The FPU presents two operands and a signedness flag with a valid/ready request handshake. The block computes the full 2*WIDTH-bit product with an iterative radix-4 Booth datapath and returns {hi, lo} under a valid/ready response handshake. It replaces the single-cycle combinational product path, so the FPU can stall on the response instead of relying on a fixed-timing ALU.

---
 rtl/fpu_mul_responder.sv | 142 ++++++++++++++
 tb/tb_fpu_mul_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_responder.sv
// Iterative radix-4 Booth multiplier serving the FPU multiply port.
// Returns the full 2*WIDTH-bit product as {hi, lo} over a valid/ready response handshake.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// BUSY  | one Booth step per clock, STEPS steps in total
// DONE  | product held on resp_hi/resp_lo until the FPU takes it
module fpu_mul_responder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_signed,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_hi,
    output logic [WIDTH-1:0] resp_lo,
    output logic             busy
);

    localparam int STEPS = (WIDTH + 2) / 2;
    localparam int EXT   = WIDTH + 2;
    localparam int ACCW  = EXT + 2;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [EXT-1:0]   a_ext;
    logic [EXT-1:0]   b_sh;
    logic             b_prev;
    logic [ACCW-1:0]  acc;
    logic [CW-1:0]    step_cnt;

    logic             accept;
    logic             last_step;
    logic [2:0]       window;
    logic [ACCW-1:0]  a_acc;
    logic [ACCW-1:0]  pp;
    logic [ACCW-1:0]  sum;
    logic [ACCW-1:0]  acc_nx;
    logic [EXT-1:0]   b_nx;
    logic [WIDTH-1:0] prod_hi_nx;

    assign accept    = (state == IDLE) && req_valid && !flush;
    assign last_step = (step_cnt == CW'(STEPS - 1));

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                // flush outranks the response handshake
                if (flush || resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Booth window is {b[1], b[0], bit shifted out on the previous step}
    always_comb begin
        window = {b_sh[1:0], b_prev};
        a_acc  = {{2{a_ext[EXT-1]}}, a_ext};
        pp     = '0;
        case (window)
            3'b001, 3'b010: pp = a_acc;
            3'b011:         pp = a_acc << 1;
            3'b100:         pp = (~(a_acc << 1)) + ACCW'(1);
            3'b101, 3'b110: pp = (~a_acc) + ACCW'(1);
            default:        pp = '0;
        endcase
        sum    = acc + pp;
        acc_nx = {{2{sum[ACCW-1]}}, sum[ACCW-1:2]};
        b_nx   = {sum[1:0], b_sh[EXT-1:2]};
        // After the final shift {acc, b_sh} holds the product; low EXT bits sit in b_sh
        prod_hi_nx = {acc_nx[WIDTH-3:0], b_nx[EXT-1:WIDTH]};
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_ext    <= '0;
            b_sh     <= '0;
            b_prev   <= 1'b0;
            acc      <= '0;
            step_cnt <= '0;
            resp_hi  <= '0;
            resp_lo  <= '0;
        end else if (accept) begin
            a_ext    <= req_signed ? {{2{req_a[WIDTH-1]}}, req_a} : {2'b00, req_a};
            b_sh     <= req_signed ? {{2{req_b[WIDTH-1]}}, req_b} : {2'b00, req_b};
            b_prev   <= 1'b0;
            acc      <= '0;
            step_cnt <= '0;
        end else if ((state == BUSY) && !flush) begin
            acc      <= acc_nx;
            b_sh     <= b_nx;
            b_prev   <= b_sh[1];
            step_cnt <= step_cnt + CW'(1);
            if (last_step) begin
                resp_hi <= prod_hi_nx;
                resp_lo <= b_nx[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fpu_mul_responder.sv
// Directed bench for fpu_mul_responder: expected products queued at issue,
// compared by a monitor on every response handshake.
module tb_fpu_mul_responder;

    logic        clk;
    logic        clr;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_hi;
    logic [31:0] resp_lo;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    fpu_mul_responder #(.WIDTH(32)) dut (
        .clk(clk),
        .clr(clr),
        .flush(flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_signed(req_signed),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_hi(resp_hi),
        .resp_lo(resp_lo),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one comparison per completed response handshake
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (resp_valid && resp_ready && !flush && !clr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got %h%h expected none", resp_hi, resp_lo);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_product", {resp_hi, resp_lo}, e);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic push, input logic [63:0] exp);
        int n = 0;
        while (!req_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) chk("issue_ready_timeout", {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_signed = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) exp_q.push_back(exp);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!resp_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!resp_valid) chk("resp_valid_timeout", {63'd0, resp_valid}, 64'd1);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp);
        int n;
        issue(a, b, s, 1'b1, exp);
        wait_valid(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic rdy_seen;
        logic valid_seen;

        clr        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_signed = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp", {resp_hi, resp_lo}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // 1: unsigned max*max, latency and req_ready while busy
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFE_00000001);
        n = 0;
        rdy_seen = 1'b0;
        while (!resp_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready) rdy_seen = 1'b1;
        end
        chk("latency_edges", 64'(n), 64'd17);
        chk("ready_low_busy_done", {63'd0, rdy_seen}, 64'd0);
        @(posedge clk);
        #1;
        chk("idle_after_handshake_ready", {63'd0, req_ready}, 64'd1);
        chk("idle_after_handshake_valid", {63'd0, resp_valid}, 64'd0);

        // 2: signed
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
        run(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
        run(32'd355, 32'hFFFFFF8F, 1'b1, 64'hFFFFFFFF_FFFF634D);
        run(32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC0000000_80000000);

        // 3: unsigned mantissa-style
        run(32'h00800000, 32'h00800000, 1'b0, 64'h00004000_00000000);
        run(32'd355, 32'd113, 1'b0, 64'h00000000_00009CB3);

        // 4: backpressure in DONE
        resp_ready = 1'b0;
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFE_00000001);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            req_valid = ~req_valid;
            req_a     = 32'h1111_0000 + 32'(i);
            req_b     = 32'h0000_2222 + 32'(i);
            @(posedge clk);
            #1;
            chk("bp_hold_product", {resp_hi, resp_lo}, 64'hFFFFFFFE_00000001);
            chk("bp_ready_low", {63'd0, req_ready}, 64'd0);
            chk("bp_valid_high", {63'd0, resp_valid}, 64'd1);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", {62'd0, req_ready, resp_valid}, 64'd2);
        @(posedge clk);
        #1;
        chk("bp_no_second_accept", {63'd0, busy}, 64'd0);

        // 5: flush mid-BUSY
        issue(32'h80000000, 32'h80000000, 1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle_ready", {63'd0, req_ready}, 64'd1);
        chk("flush_busy_low", {63'd0, busy}, 64'd0);
        chk("flush_keeps_resp", {resp_hi, resp_lo}, 64'hFFFFFFFE_00000001);
        valid_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) valid_seen = 1'b1;
        end
        chk("flush_no_resp", {63'd0, valid_seen}, 64'd0);
        run(32'd355, 32'd113, 1'b0, 64'h00000000_00009CB3);

        // 6: asynchronous clr mid-BUSY, clr beats req_valid
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        clr = 1'b1;
        #1;
        chk("clr_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("clr_busy", {63'd0, busy}, 64'd0);
        chk("clr_req_ready", {63'd0, req_ready}, 64'd1);
        chk("clr_resp_zero", {resp_hi, resp_lo}, 64'd0);
        req_valid = 1'b1;
        req_a     = 32'd7;
        req_b     = 32'd9;
        @(posedge clk);
        #3;
        req_valid = 1'b0;
        clr       = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_wins_no_accept", {63'd0, busy}, 64'd0);
        run(32'd355, 32'hFFFFFF8F, 1'b1, 64'hFFFFFFFF_FFFF634D);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
